// File: rtl/tick_scheduler.sv
// Two-rate game tick generator plus run/score lifecycle (BCD score, level, high score).
// game_tick[1] follows every frame; game_tick[0] fires every `period` frames, shrinking with level.
module tick_scheduler #(
  parameter int unsigned BASE_PERIOD = 6,
  parameter int unsigned MIN_PERIOD  = 2,
  parameter int unsigned LEVEL_MAX   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_pulse,
  input  logic        game_start_pulse,
  input  logic        game_over_pulse,
  output logic [1:0]  game_tick,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [2:0]  level,
  output logic        new_high,
  output logic        running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        start_ok, over_ok;
  logic [3:0]  frame_cnt;
  logic [3:0]  period;
  logic [4:0]  level_ext;
  logic        tick0_fire;
  logic        score_inc;
  logic [15:0] score_next;
  logic        level_up;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    over_ok    = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (game_start_pulse) begin
          start_ok   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (game_over_pulse) begin
          over_ok    = 1'b1;
          state_next = OVER;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // period = max(BASE_PERIOD - level, MIN_PERIOD), computed without underflow
  always_comb begin
    level_ext = {2'b00, level};
    if (level_ext + 5'(MIN_PERIOD) >= 5'(BASE_PERIOD)) begin
      period = 4'(MIN_PERIOD);
    end else begin
      period = 4'(5'(BASE_PERIOD) - level_ext);
    end
  end

  // >= rather than == so a period shrink never leaves the counter stranded above the new limit
  always_comb begin
    tick0_fire = frame_pulse && !start_ok && (frame_cnt >= period - 4'd1);
    score_inc  = (state == RUN) && tick0_fire && (score != 16'h9999);
    score_next = score_inc ? bcd_inc(score) : score;
    level_up   = score_inc && (score_next[7:0] == 8'h00) && (level < 3'(LEVEL_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      game_tick <= '0;
      frame_cnt <= '0;
      score     <= '0;
      hi_score  <= '0;
      level     <= '0;
      new_high  <= 1'b0;
      running   <= 1'b0;
    end else begin
      running   <= (state_next == RUN);
      game_tick <= {frame_pulse, tick0_fire};

      if (start_ok || (frame_pulse && tick0_fire)) begin
        frame_cnt <= '0;
      end else if (frame_pulse) begin
        frame_cnt <= frame_cnt + 4'd1;
      end

      if (start_ok) begin
        score    <= '0;
        level    <= '0;
        new_high <= 1'b0;
      end else begin
        score <= score_next;
        if (level_up) begin
          level <= level + 3'd1;
        end
        // compare against the post-increment score so a coincident final tick counts
        if (over_ok && (score_next > hi_score)) begin
          hi_score <= score_next;
          new_high <= 1'b1;
        end
      end
    end
  end

endmodule
